// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller:
// default widths, request op encodings and controller states.
package mem_access_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // Wide enough to count READ_LAT cycles up to its legal maximum of 4
    localparam int LAT_CNT_W  = 3;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_VFY,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator side of the 16x8 data memory interface. Takes load/store/copy
// requests over a valid/ready handshake, drives r_w/enable/addresses/write
// data toward the memory bank and returns a response over valid/ready.
// r_w only drops to 0 for the single WR cycle of a store or copy.
// Optional feature macro: MEM_WRITE_VERIFY_EN (read back each write and flag
// a mismatch in rsp_err).
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              r_w,
    output logic              enable
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LAT - 1);

    state_t                r_state;
    op_t                   r_op;
    logic [ADDR_W-1:0]     r_addr2;
    logic [LAT_CNT_W-1:0]  r_lat_cnt;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_data;
    logic                  r_rsp_err;
    logic [ADDR_W-1:0]     r_mem_addr_out;
    logic [ADDR_W-1:0]     r_mem_addr_in;
    logic [DATA_W-1:0]     r_mem_data_in;
    logic                  r_rw;
    logic                  r_en;

    // Sequencer: state, latency counter and every output register move together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_LOAD;
            r_addr2        <= '0;
            r_lat_cnt      <= '0;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_mem_addr_out <= '0;
            r_mem_addr_in  <= '0;
            r_mem_data_in  <= '0;
            r_rw           <= 1'b1;
            r_en           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_op        <= op_t'(req_op);
                        r_addr2     <= req_addr2;
                        r_req_ready <= 1'b0;
                        case (op_t'(req_op))
                            OP_LOAD, OP_COPY: begin
                                r_state        <= ST_RD;
                                r_rw           <= 1'b1;
                                r_en           <= 1'b1;
                                r_mem_addr_out <= req_addr;
                                r_lat_cnt      <= '0;
                            end
                            OP_STORE: begin
                                r_state       <= ST_WR;
                                r_rw          <= 1'b0;
                                r_en          <= 1'b1;
                                r_mem_addr_in <= req_addr;
                                r_mem_data_in <= req_wdata;
                            end
                            default: begin
                                r_state     <= ST_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= '0;
                                r_rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_RD: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        if (r_op == OP_COPY) begin
                            // Captured byte goes straight into the write-data register
                            r_state       <= ST_WR;
                            r_rw          <= 1'b0;
                            r_mem_addr_in <= r_addr2;
                            r_mem_data_in <= mem_data_out;
                        end else begin
                            r_state     <= ST_RESP;
                            r_en        <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= mem_data_out;
                            r_rsp_err   <= 1'b0;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end

                ST_WR: begin
                    r_rw <= 1'b1;
`ifdef MEM_WRITE_VERIFY_EN
                    r_state        <= ST_VFY;
                    r_mem_addr_out <= r_mem_addr_in;
                    r_lat_cnt      <= '0;
`else
                    r_state     <= ST_RESP;
                    r_en        <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_mem_data_in;
                    r_rsp_err   <= 1'b0;
`endif
                end

`ifdef MEM_WRITE_VERIFY_EN
                ST_VFY: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_state     <= ST_RESP;
                        r_en        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_mem_data_in;
                        r_rsp_err   <= (mem_data_out != r_mem_data_in);
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
`endif

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_rw        <= 1'b1;
                    r_en        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign mem_addr_out = r_mem_addr_out;
    assign mem_addr_in  = r_mem_addr_in;
    assign mem_data_in  = r_mem_data_in;
    assign r_w          = r_rw;
    assign enable       = r_en;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the 16x8 data memory interface. Accepts load/store/copy requests from the CPU datapath over a valid/ready handshake and sequences r_w, enable, read/write addresses and write data toward the memory bank. Returns read data (or copied byte) over a valid/ready response channel. Guarantees the memory never sees r_w=0 outside a deliberate single-cycle write.

Parameters:
DATA_W, 8, data width of memory words and request/response data
ADDR_W, 4, memory address width (16 locations)
READ_LAT, 1, cycles a read address is held before mem_data_out is sampled; legal range 1..4

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_op  input  2  00 load, 01 store, 10 copy (addr -> addr2), 11 reserved
req_addr  input  ADDR_W  load/store address; copy source
req_addr2  input  ADDR_W  copy destination
req_wdata  input  DATA_W  store data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_data  output  DATA_W  load data / copied byte / store data echo
rsp_err  output  1  error flag, qualified by rsp_valid
mem_addr_out  output  ADDR_W  read address to memory
mem_addr_in  output  ADDR_W  write address to memory
mem_data_in  output  DATA_W  write data to memory
mem_data_out  input  DATA_W  read data from memory
r_w  output  1  1 read, 0 write
enable  output  1  memory access active

Behaviour:
- Clock clk, reset synchronous active-high; all outputs registered.
- Reset values: req_ready=0 while reset high, 1 in first cycle after; rsp_valid=0, rsp_data=0, rsp_err=0, r_w=1, enable=0, all addresses/mem_data_in=0; state IDLE; latency counter 0.
- States: IDLE, RD, WR, VFY (feature only), RESP.
- IDLE: req_ready=1. Accept on edge T0 where req_valid&&req_ready; capture op, addr, addr2, wdata. load/copy -> RD; store -> WR; reserved -> RESP with rsp_err=1, no memory access.
- RD: r_w=1, enable=1, mem_addr_out=req_addr, held READ_LAT cycles (counter); mem_data_out sampled into data register at edge ending last RD cycle. load -> RESP; copy -> WR.
- WR: exactly one cycle; r_w=0, enable=1, mem_addr_in = addr (store) or addr2 (copy), mem_data_in = wdata (store) or captured byte (copy). Then RESP (or VFY).
- RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready sampled high; then IDLE. req_ready=0 in every non-IDLE state; no request overlap.
- Latency (accept edge T0 to first rsp_valid cycle): load T0+READ_LAT+1; store T0+2; copy T0+READ_LAT+2; reserved T0+1.
- Outside WR: r_w=1 always; enable=0 in IDLE/RESP.
- Copy with addr==addr2: performed normally (read then rewrite same value).
- rsp_ready high while rsp_valid low: ignored. req_* changes after accept: ignored.
- Reset mid-operation: abort immediately; if reset asserted during WR, outputs return to reset values at next edge, no further write cycle issued; pending response discarded.

Optional Feature:
MEM_WRITE_VERIFY_EN: defined -> after WR, enter VFY: read back written address for READ_LAT cycles (r_w=1, enable=1); rsp_err=1 if readback != written data; store/copy latency +READ_LAT. Undefined -> VFY absent, rsp_err set only for reserved op.

Decomposition:
- Package mem_access_pkg: op encodings (OP_LOAD, OP_STORE, OP_COPY, OP_RSVD), state enum, default DATA_W/ADDR_W constants.
- Single module; no sub-module warranted (latency counter inline).

Test Plan:
- Store 8'hA5 to addr 3, then load addr 3 (READ_LAT=1) -> one r_w=0 cycle with mem_addr_in=3; load rsp_data=8'hA5, rsp_err=0, rsp_valid at T0+2.
- Copy addr 3 -> addr 9 after above -> memory[9]=8'hA5, rsp_data=8'hA5, single write cycle, rsp_valid at T0+3.
- req_op=11 -> rsp_valid at T0+1, rsp_err=1, enable never asserted, r_w stays 1.
- Hold rsp_ready=0 for 5 cycles on load -> rsp_valid/rsp_data stable, req_ready=0 throughout, new req_valid not accepted.
- Assert reset in WR cycle of store -> next cycle r_w=1, enable=0, rsp_valid=0, req_ready=0; req_ready=1 one cycle after reset drops.
- With MEM_WRITE_VERIFY_EN and memory model forcing addr 5 to 8'h00, store 8'h3C to addr 5 -> rsp_err=1, latency T0+3.
